// File: rtl/mem_bank_req_issuer.sv
// Per-bank SRAM issue stage: credit-limited req/gnt issue, fixed-latency read tracking, in-order response buffer.
// Optional MEM_BANK_ISSUER_REQ_REG_EN inserts a one-entry request register between the FIFO and the bank.
module mem_bank_req_issuer #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned WUserWidth     = 1,
  parameter int unsigned MemLatency     = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  input  logic [AddrWidth+DataWidth+DataWidth/8+WUserWidth:0]    req_data_i,
  input  logic                                                   req_empty_i,
  output logic                                                   req_pop_o,
  output logic                                                   mem_req_o,
  input  logic                                                   mem_gnt_i,
  output logic                                                   mem_we_o,
  output logic [AddrWidth-1:0]                                   mem_addr_o,
  output logic [DataWidth-1:0]                                   mem_wdata_o,
  output logic [DataWidth/8-1:0]                                 mem_strb_o,
  output logic [WUserWidth-1:0]                                  mem_wuser_o,
  input  logic [DataWidth-1:0]                                   mem_rdata_i,
  output logic                                                   rsp_valid_o,
  input  logic                                                   rsp_ready_i,
  output logic                                                   rsp_we_o,
  output logic [DataWidth-1:0]                                   rsp_rdata_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned ReqWidth  = AddrWidth + DataWidth + StrbWidth + WUserWidth + 1;
  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  logic [CntWidth-1:0] cnt;
  logic                credit_ok;
  logic                grant;
  logic                consume;
  logic                credit_take;
  logic [ReqWidth-1:0] req_sel;

  assign credit_ok = (cnt < MaxCnt);
  assign grant     = mem_req_o & mem_gnt_i;
  assign consume   = rsp_valid_o & rsp_ready_i;

`ifdef MEM_BANK_ISSUER_REQ_REG_EN
  // Request register: refills when empty or when its entry is granted this cycle.
  logic                reg_vld;
  logic [ReqWidth-1:0] reg_q;
  logic                load;

  assign load        = ~req_empty_i & credit_ok & (~reg_vld | grant);
  assign req_pop_o   = load;
  assign mem_req_o   = reg_vld;
  assign req_sel     = reg_q;
  // The credit is taken on load and carried by the registered entry into the pipe.
  assign credit_take = load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_vld <= 1'b0;
      reg_q   <= '0;
    end else if (load) begin
      reg_vld <= 1'b1;
      reg_q   <= req_data_i;
    end else if (grant) begin
      reg_vld <= 1'b0;
    end
  end
`else
  // Direct path: FIFO head is non-fall-through, so fields hold until grant.
  assign mem_req_o   = ~req_empty_i & credit_ok;
  assign req_pop_o   = grant;
  assign req_sel     = req_data_i;
  assign credit_take = grant;
`endif

  assign mem_we_o    = req_sel[ReqWidth-1];
  assign mem_addr_o  = req_sel[ReqWidth-2 -: AddrWidth];
  assign mem_wdata_o = req_sel[StrbWidth+WUserWidth +: DataWidth];
  assign mem_strb_o  = req_sel[WUserWidth +: StrbWidth];
  assign mem_wuser_o = req_sel[WUserWidth-1:0];

  // Latency pipe tracks {valid, we} of granted requests until read data is due.
  logic [MemLatency-1:0] pipe_vld;
  logic [MemLatency-1:0] pipe_we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld <= '0;
      pipe_we  <= '0;
    end else begin
      pipe_vld[0] <= grant;
      pipe_we[0]  <= mem_we_o;
      for (int i = 1; i < int'(MemLatency); i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_we[i]  <= pipe_we[i-1];
      end
    end
  end

  logic                 push;
  logic                 push_we;
  logic [DataWidth-1:0] push_data;

  assign push      = pipe_vld[MemLatency-1];
  assign push_we   = pipe_we[MemLatency-1];
  assign push_data = push_we ? '0 : mem_rdata_i;

  // Response buffer, sized so that every credited request has a slot.
  logic [DataWidth-1:0]      buf_data [MaxOutstanding];
  logic [MaxOutstanding-1:0] buf_we;
  logic [PtrWidth-1:0]       wptr;
  logic [PtrWidth-1:0]       rptr;
  logic [CntWidth-1:0]       occ;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) buf_data[i] <= '0;
      buf_we <= '0;
      wptr   <= '0;
      rptr   <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        buf_data[wptr] <= push_data;
        buf_we[wptr]   <= push_we;
        wptr           <= next_ptr(wptr);
      end
      if (consume) rptr <= next_ptr(rptr);
      case ({push, consume})
        2'b10:   occ <= occ + CntWidth'(1);
        2'b01:   occ <= occ - CntWidth'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign rsp_valid_o = (occ != '0);
  assign rsp_we_o    = buf_we[rptr];
  assign rsp_rdata_o = buf_data[rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else begin
      case ({credit_take, consume})
        2'b10:   cnt <= cnt + CntWidth'(1);
        2'b01:   cnt <= cnt - CntWidth'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !consume && (occ == MaxCnt)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(consume && (occ == '0)));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt <= MaxCnt));

endmodule

// File: tb/tb_mem_bank_req_issuer.sv
// Directed bench: instance a (latency 1, 2 outstanding) and instance b (latency 3, 4 outstanding).
module tb_mem_bank_req_issuer;

  localparam int unsigned RW = 70;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Instance a signals
  logic [RW-1:0] req_data_a;
  logic          req_empty_a, req_pop_a, mem_req_a, mem_gnt_a, mem_we_a;
  logic [31:0]   mem_addr_a, mem_wdata_a, mem_rdata_a, rsp_rdata_a;
  logic [3:0]    mem_strb_a;
  logic [0:0]    mem_wuser_a;
  logic          rsp_valid_a, rsp_ready_a, rsp_we_a;
  // Instance b signals
  logic [RW-1:0] req_data_b;
  logic          req_empty_b, req_pop_b, mem_req_b, mem_gnt_b, mem_we_b;
  logic [31:0]   mem_addr_b, mem_wdata_b, mem_rdata_b, rsp_rdata_b;
  logic [3:0]    mem_strb_b;
  logic [0:0]    mem_wuser_b;
  logic          rsp_valid_b, rsp_ready_b, rsp_we_b;

  mem_bank_req_issuer #(.AddrWidth(32), .DataWidth(32), .WUserWidth(1), .MemLatency(1), .MaxOutstanding(2)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_data_i(req_data_a), .req_empty_i(req_empty_a), .req_pop_o(req_pop_a),
    .mem_req_o(mem_req_a), .mem_gnt_i(mem_gnt_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
    .mem_wdata_o(mem_wdata_a), .mem_strb_o(mem_strb_a), .mem_wuser_o(mem_wuser_a), .mem_rdata_i(mem_rdata_a),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_a), .rsp_we_o(rsp_we_a), .rsp_rdata_o(rsp_rdata_a));

  mem_bank_req_issuer #(.AddrWidth(32), .DataWidth(32), .WUserWidth(1), .MemLatency(3), .MaxOutstanding(4)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_data_i(req_data_b), .req_empty_i(req_empty_b), .req_pop_o(req_pop_b),
    .mem_req_o(mem_req_b), .mem_gnt_i(mem_gnt_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
    .mem_wdata_o(mem_wdata_b), .mem_strb_o(mem_strb_b), .mem_wuser_o(mem_wuser_b), .mem_rdata_i(mem_rdata_b),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b), .rsp_we_o(rsp_we_b), .rsp_rdata_o(rsp_rdata_b));

  // Non-fall-through request FIFO models
  logic [RW-1:0] fifo_a [32];
  logic [RW-1:0] fifo_b [32];
  int unsigned rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
  assign req_data_a  = fifo_a[rd_a[4:0]];
  assign req_empty_a = (rd_a == wr_a);
  assign req_data_b  = fifo_b[rd_b[4:0]];
  assign req_empty_b = (rd_b == wr_b);

  // SRAM models: read data is a function of the address presented MemLatency cycles earlier
  logic [31:0] sr_a;
  logic [31:0] sr_b [3];
  assign mem_rdata_a = (sr_a == 32'h40) ? 32'hDEADBEEF : sr_a + 32'h1000;
  assign mem_rdata_b = sr_b[2] >> 2;

  always @(posedge clk_i) begin
    if (req_pop_a) rd_a <= rd_a + 1;
    if (req_pop_b) rd_b <= rd_b + 1;
    sr_a    <= mem_addr_a;
    sr_b[0] <= mem_addr_b;
    sr_b[1] <= sr_b[0];
    sr_b[2] <= sr_b[1];
  end

  function automatic logic [RW-1:0] mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [3:0] strb, input logic wuser);
    return {we, addr, wdata, strb, wuser};
  endfunction

  task automatic push_a(input logic [RW-1:0] r);
    fifo_a[wr_a[4:0]] = r;
    wr_a = wr_a + 1;
  endtask

  task automatic push_b(input logic [RW-1:0] r);
    fifo_b[wr_b[4:0]] = r;
    wr_b = wr_b + 1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    mem_gnt_a = 1'b0; rsp_ready_a = 1'b0; mem_gnt_b = 1'b0; rsp_ready_b = 1'b0;
    repeat (3) tick();
    checks++; if (mem_req_a !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req_a); end
    checks++; if (req_pop_a !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", req_pop_a); end
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_a); end
    checks++; if (rsp_we_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_we: got %b want 0", rsp_we_a); end
    checks++; if (rsp_rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata_a); end
    checks++; if (rsp_valid_b !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid_b: got %b want 0", rsp_valid_b); end
    rst_ni = 1'b1;
    tick();
    checks++; if (u_a.cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt_a: got %0d want 0", u_a.cnt); end
    checks++; if (u_b.cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt_b: got %0d want 0", u_b.cnt); end
  endtask

  task automatic test_read();
    mem_gnt_a = 1'b1; rsp_ready_a = 1'b0;
    push_a(mk(1'b0, 32'h40, 32'h0, 4'h0, 1'b0));
    #1;
    checks++; if ({mem_req_a, mem_we_a, mem_addr_a, req_pop_a} !== {1'b1, 1'b0, 32'h40, 1'b1}) begin
      errors++; $display("FAIL read_issue: got req=%b we=%b addr=%h pop=%b want 1 0 00000040 1",
                         mem_req_a, mem_we_a, mem_addr_a, req_pop_a); end
    tick();
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL read_early_valid: got %b want 0", rsp_valid_a); end
    tick();
    checks++; if ({rsp_valid_a, rsp_we_a, rsp_rdata_a} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_rsp: got v=%b we=%b d=%h want 1 0 deadbeef", rsp_valid_a, rsp_we_a, rsp_rdata_a); end
    rsp_ready_a = 1'b1;
    tick();
    rsp_ready_a = 1'b0;
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL read_consumed: got %b want 0", rsp_valid_a); end
  endtask

  task automatic test_write();
    mem_gnt_a = 1'b1; rsp_ready_a = 1'b0;
    push_a(mk(1'b1, 32'h80, 32'h12345678, 4'hF, 1'b1));
    #1;
    checks++; if ({mem_req_a, mem_we_a, mem_addr_a, mem_wdata_a, mem_strb_a, mem_wuser_a, req_pop_a} !==
                  {1'b1, 1'b1, 32'h80, 32'h12345678, 4'hF, 1'b1, 1'b1}) begin
      errors++; $display("FAIL write_fields: got req=%b we=%b addr=%h wd=%h strb=%h wu=%b pop=%b want 1 1 80 12345678 f 1 1",
                         mem_req_a, mem_we_a, mem_addr_a, mem_wdata_a, mem_strb_a, mem_wuser_a, req_pop_a); end
    repeat (2) tick();
    checks++; if ({rsp_valid_a, rsp_we_a, rsp_rdata_a} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL write_rsp: got v=%b we=%b d=%h want 1 1 00000000", rsp_valid_a, rsp_we_a, rsp_rdata_a); end
    rsp_ready_a = 1'b1;
    tick();
    rsp_ready_a = 1'b0;
  endtask

  task automatic test_credit_stall();
    int pops;
    mem_gnt_a = 1'b1; rsp_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) push_a(mk(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 1'b0));
    #1;
    pops = 0;
    repeat (6) begin if (req_pop_a) pops++; tick(); end
    checks++; if (pops !== 2) begin errors++; $display("FAIL stall_grants: got %0d want 2", pops); end
    checks++; if (mem_req_a !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", mem_req_a); end
    checks++; if ({rsp_valid_a, rsp_rdata_a} !== {1'b1, 32'h1100}) begin
      errors++; $display("FAIL stall_head: got v=%b d=%h want 1 00001100", rsp_valid_a, rsp_rdata_a); end
    for (int r = 0; r < 2; r++) begin
      rsp_ready_a = 1'b1;
      checks++; if (mem_req_a !== 1'b0) begin errors++; $display("FAIL stall_req_consume_cycle: got %b want 0", mem_req_a); end
      tick();
      rsp_ready_a = 1'b0;
      checks++; if ({mem_req_a, req_pop_a} !== 2'b11) begin
        errors++; $display("FAIL stall_reenable: got req=%b pop=%b want 1 1", mem_req_a, req_pop_a); end
      pops = 0;
      repeat (4) begin if (req_pop_a) pops++; tick(); end
      checks++; if (pops !== 1) begin errors++; $display("FAIL stall_one_grant: got %0d want 1", pops); end
      checks++; if ({rsp_valid_a, rsp_rdata_a} !== {1'b1, 32'h1104 + 32'(4 * r)}) begin
        errors++; $display("FAIL stall_order: got v=%b d=%h want 1 %h", rsp_valid_a, rsp_rdata_a, 32'h1104 + 32'(4 * r)); end
    end
    rsp_ready_a = 1'b1;
    pops = 0;
    repeat (8) begin if (req_pop_a) pops++; tick(); end
    rsp_ready_a = 1'b0;
    checks++; if (pops !== 1) begin errors++; $display("FAIL stall_drain_grants: got %0d want 1", pops); end
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL stall_drained: got %b want 0", rsp_valid_a); end
  endtask

  task automatic test_gnt_stall();
    mem_gnt_a = 1'b0; rsp_ready_a = 1'b0;
    push_a(mk(1'b1, 32'h200, 32'hAABBCCDD, 4'h5, 1'b1));
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({mem_req_a, mem_we_a, mem_addr_a, mem_wdata_a, mem_strb_a, mem_wuser_a, req_pop_a} !==
                    {1'b1, 1'b1, 32'h200, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0}) begin
        errors++; $display("FAIL gnt_hold_%0d: got req=%b we=%b addr=%h wd=%h strb=%h wu=%b pop=%b want 1 1 200 aabbccdd 5 1 0",
                           i, mem_req_a, mem_we_a, mem_addr_a, mem_wdata_a, mem_strb_a, mem_wuser_a, req_pop_a); end
      tick();
    end
    mem_gnt_a = 1'b1;
    #1;
    checks++; if (req_pop_a !== 1'b1) begin errors++; $display("FAIL gnt_pop: got %b want 1", req_pop_a); end
    tick();
    checks++; if ({mem_req_a, req_pop_a} !== 2'b00) begin
      errors++; $display("FAIL gnt_single_pop: got req=%b pop=%b want 0 0", mem_req_a, req_pop_a); end
    rsp_ready_a = 1'b1;
    repeat (3) tick();
    rsp_ready_a = 1'b0;
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL gnt_drained: got %b want 0", rsp_valid_a); end
  endtask

  task automatic test_back_to_back();
    int pops, first4, idx;
    mem_gnt_b = 1'b1; rsp_ready_b = 1'b1;
    for (int i = 0; i < 8; i++) push_b(mk(1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b0));
    #1;
    pops = 0; first4 = 0; idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (req_pop_b) begin pops++; if (cyc < 4) first4++; end
      if (cyc == 4) begin
        checks++; if (mem_req_b !== 1'b0) begin errors++; $display("FAIL b2b_credit_stall: got %b want 0", mem_req_b); end
      end
      if (rsp_valid_b) begin
        checks++; if ({rsp_we_b, rsp_rdata_b} !== {1'b0, 32'(idx)}) begin
          errors++; $display("FAIL b2b_rsp_%0d: got we=%b d=%h want 0 %h", idx, rsp_we_b, rsp_rdata_b, 32'(idx)); end
        idx++;
      end
      tick();
    end
    rsp_ready_b = 1'b0;
    checks++; if (first4 !== 4) begin errors++; $display("FAIL b2b_first_grants: got %0d want 4", first4); end
    checks++; if (pops !== 8) begin errors++; $display("FAIL b2b_grants: got %0d want 8", pops); end
    checks++; if (idx !== 8) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 8", idx); end
  endtask

  task automatic test_reset_midflight();
    int found;
    mem_gnt_b = 1'b1; rsp_ready_b = 1'b0;
    push_b(mk(1'b0, 32'h40, 32'h0, 4'h0, 1'b0));
    push_b(mk(1'b0, 32'h44, 32'h0, 4'h0, 1'b0));
    #1;
    repeat (2) tick();
    mem_gnt_b = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++; if (rsp_valid_b !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", rsp_valid_b); end
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid_b !== 1'b0) begin errors++; $display("FAIL rst_late_data_%0d: got %b want 0", i, rsp_valid_b); end
      tick();
    end
    checks++; if (u_b.cnt !== 3'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", u_b.cnt); end
    checks++; if (mem_req_b !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 0", mem_req_b); end
    mem_gnt_b = 1'b1; rsp_ready_b = 1'b1;
    push_b(mk(1'b0, 32'h20, 32'h0, 4'h0, 1'b0));
    #1;
    found = 0;
    repeat (8) begin if (rsp_valid_b && rsp_rdata_b == 32'h8) found++; tick(); end
    rsp_ready_b = 1'b0;
    checks++; if (found !== 1) begin errors++; $display("FAIL rst_recover: got %0d responses want 1", found); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_gnt_a = 1'b0; rsp_ready_a = 1'b0; mem_gnt_b = 1'b0; rsp_ready_b = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_credit_stall();
    test_gnt_stall();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
